iob_cache_axi_read_responder: RTL and testbench

//  AXI4 read-channel responder (AR/R slave) in front of a single-port synchronous RAM.

---
 rtl/iob_cache_axi_read_responder_if.sv | 32 +++
 rtl/iob_cache_axi_read_responder.sv | 138 +++++++++++++
 tb/tb_iob_cache_axi_read_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/iob_cache_axi_read_responder_if.sv
// AXI4 read address / read data channel bundle between a read master and
// the read responder in front of the backing RAM.
interface iob_cache_axi_read_responder_if #(
    parameter int ID_W   = 1,
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/iob_cache_axi_read_responder.sv
// AXI4 read responder: accepts one AR burst at a time and streams arlen+1
// R beats out of a single-port synchronous RAM with one cycle read latency.
module iob_cache_axi_read_responder #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                  clk_i,
    input  logic                  reset,
    iob_cache_axi_read_responder_if.slave axi,
    output logic                  mem_en_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    input  logic [AXI_DATA_W-1:0] mem_rdata_i
);

    localparam int NBYTES_W = $clog2(AXI_DATA_W / 8);
    localparam int RANGE_W  = MEM_ADDR_W + NBYTES_W;
    localparam logic [2:0] SIZE_CODE = 3'(NBYTES_W);
    localparam logic [AXI_ADDR_W-1:0] BEAT_BYTES = AXI_ADDR_W'(1) << NBYTES_W;

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t                state;
    logic [AXI_ID_W-1:0]   id_q;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [AXI_LEN_W-1:0]  len_q;
    logic [AXI_LEN_W-1:0]  beat_cnt;
    logic                  err_cfg;
    logic                  incr_q;
    logic                  beat_err;
    logic                  arready_q;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic [1:0]            rresp_q;
    logic [AXI_ID_W-1:0]   rid_q;
    logic                  mem_en_q;
    logic [MEM_ADDR_W-1:0] mem_addr_q;

    logic                  accept;
    logic                  req_err_cfg;
    logic [AXI_ADDR_W-1:0] next_addr;
    logic [AXI_ADDR_W-1:0] fetch_addr;
    logic                  fetch_err;

    // The RAM read for a beat is launched on the same edge that enters FETCH,
    // so the address and its range check are worked out one cycle ahead.
    always_comb begin
        accept      = axi.arvalid & arready_q;
        req_err_cfg = (axi.arsize != SIZE_CODE) | axi.arburst[1];
        next_addr   = incr_q ? addr_q + BEAT_BYTES : addr_q;
        fetch_addr  = next_addr;
        fetch_err   = err_cfg;
        if (state == IDLE) begin
            fetch_addr = axi.araddr;
            fetch_err  = req_err_cfg;
        end
        fetch_err = fetch_err | ((fetch_addr >> RANGE_W) != '0);
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state      <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt   <= '0;
            err_cfg    <= 1'b0;
            incr_q     <= 1'b0;
            beat_err   <= 1'b0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= 2'b00;
            rid_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q      <= axi.arid;
                        rid_q     <= axi.arid;
                        addr_q    <= axi.araddr;
                        len_q     <= axi.arlen;
                        err_cfg   <= req_err_cfg;
                        incr_q    <= (axi.arburst == 2'b01);
                        beat_cnt  <= '0;
                        beat_err  <= fetch_err;
                        mem_en_q  <= ~fetch_err;
                        if (!fetch_err) mem_addr_q <= fetch_addr[NBYTES_W +: MEM_ADDR_W];
                        arready_q <= 1'b0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    mem_en_q <= 1'b0;
                    rvalid_q <= 1'b1;
                    rid_q    <= id_q;
                    rlast_q  <= (beat_cnt == len_q);
                    rresp_q  <= beat_err ? 2'b10 : 2'b00;
                    state    <= DATA;
                end
                DATA: begin
                    if (axi.rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        rresp_q  <= 2'b00;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + AXI_LEN_W'(1);
                            addr_q   <= next_addr;
                            beat_err <= fetch_err;
                            mem_en_q <= ~fetch_err;
                            if (!fetch_err) mem_addr_q <= fetch_addr[NBYTES_W +: MEM_ADDR_W];
                            state    <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM output is held while mem_en is low, so forwarding it keeps rdata stable under stall.
    assign axi.rdata   = (rvalid_q & ~beat_err) ? mem_rdata_i : '0;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rlast   = rlast_q;
    assign axi.rresp   = rresp_q;
    assign axi.rid     = rid_q;
    assign mem_en_o    = mem_en_q;
    assign mem_addr_o  = mem_addr_q;

endmodule

// File: tb/tb_iob_cache_axi_read_responder.sv
// Directed bench for the AXI read responder: a table of bursts with
// hand-computed beats, plus stall, mid-burst reset and maximum-length cases.
module tb_iob_cache_axi_read_responder;

    logic        clk_i = 1'b0;
    logic        reset;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem [1024];

    always #5 clk_i = ~clk_i;

    iob_cache_axi_read_responder_if #(.ID_W(1), .LEN_W(8), .ADDR_W(24), .DATA_W(32)) axi ();

    iob_cache_axi_read_responder #(
        .AXI_ID_W(1), .AXI_LEN_W(8), .AXI_ADDR_W(24), .AXI_DATA_W(32), .MEM_ADDR_W(10)
    ) dut (
        .clk_i(clk_i),
        .reset(reset),
        .axi(axi),
        .mem_en_o(mem_en),
        .mem_addr_o(mem_addr),
        .mem_rdata_i(mem_rdata)
    );

    // Synchronous RAM, one cycle latency, output held while not enabled
    always @(posedge clk_i) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [0:0]       id;
        logic [23:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0]       fetch;
        logic [3:0][9:0]  maddr;
        logic [3:0][31:0] data;
        logic [3:0][1:0]  resp;
    } vec_t;

    vec_t vecs [6];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic setVec(input int v, input logic [0:0] id, input logic [23:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        vecs[v].id    = id;
        vecs[v].addr  = addr;
        vecs[v].len   = len;
        vecs[v].size  = size;
        vecs[v].burst = burst;
    endtask

    task automatic setBeat(input int v, input int b, input logic fetch, input logic [9:0] maddr,
                           input logic [31:0] data, input logic [1:0] resp);
        vecs[v].fetch[b] = fetch;
        vecs[v].maddr[b] = maddr;
        vecs[v].data[b]  = data;
        vecs[v].resp[b]  = resp;
    endtask

    task automatic issueAr(input string tag, input logic [0:0] id, input logic [23:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        @(negedge clk_i);
        axi.arid    = id;
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arsize  = size;
        axi.arburst = burst;
        axi.arvalid = 1'b1;
        checkOutput({tag, " arready"}, 32'(axi.arready), 32'd1);
        @(posedge clk_i);
        #1;
        axi.arvalid = 1'b0;
    endtask

    task automatic checkFetch(input string tag, input logic fetch, input logic [9:0] maddr);
        @(negedge clk_i);
        checkOutput({tag, " fetch rvalid"}, 32'(axi.rvalid), 32'd0);
        checkOutput({tag, " mem_en"}, 32'(mem_en), 32'(fetch));
        if (fetch) checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'(maddr));
    endtask

    task automatic checkData(input string tag, input logic [0:0] id, input logic [31:0] data,
                             input logic [1:0] resp, input logic last);
        @(negedge clk_i);
        checkOutput({tag, " rvalid"}, 32'(axi.rvalid), 32'd1);
        checkOutput({tag, " rid"}, 32'(axi.rid), 32'(id));
        checkOutput({tag, " rdata"}, axi.rdata, data);
        checkOutput({tag, " rresp"}, 32'(axi.rresp), 32'(resp));
        checkOutput({tag, " rlast"}, 32'(axi.rlast), 32'(last));
        checkOutput({tag, " data mem_en"}, 32'(mem_en), 32'd0);
    endtask

    task automatic checkIdle(input string tag);
        @(negedge clk_i);
        checkOutput({tag, " idle arready"}, 32'(axi.arready), 32'd1);
        checkOutput({tag, " idle rvalid"}, 32'(axi.rvalid), 32'd0);
        checkOutput({tag, " idle mem_en"}, 32'(mem_en), 32'd0);
    endtask

    task automatic applyStimulus(input int v);
        string tag;
        tag = $sformatf("v%0d", v);
        issueAr(tag, vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
        for (int b = 0; b <= int'(vecs[v].len); b++) begin
            tag = $sformatf("v%0d.b%0d", v, b);
            checkFetch(tag, vecs[v].fetch[b], vecs[v].maddr[b]);
            checkData(tag, vecs[v].id, vecs[v].data[b], vecs[v].resp[b], b == int'(vecs[v].len));
        end
        checkIdle($sformatf("v%0d", v));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 | 32'(i);

        setVec(0, 1'b0, 24'h000040, 8'd3, 3'd2, 2'b01);
        setBeat(0, 0, 1'b1, 10'h010, 32'h5A00_0010, 2'b00);
        setBeat(0, 1, 1'b1, 10'h011, 32'h5A00_0011, 2'b00);
        setBeat(0, 2, 1'b1, 10'h012, 32'h5A00_0012, 2'b00);
        setBeat(0, 3, 1'b1, 10'h013, 32'h5A00_0013, 2'b00);
        setVec(1, 1'b1, 24'h000FF8, 8'd3, 3'd2, 2'b01);
        setBeat(1, 0, 1'b1, 10'h3FE, 32'h5A00_03FE, 2'b00);
        setBeat(1, 1, 1'b1, 10'h3FF, 32'h5A00_03FF, 2'b00);
        setBeat(1, 2, 1'b0, 10'h000, 32'h0000_0000, 2'b10);
        setBeat(1, 3, 1'b0, 10'h000, 32'h0000_0000, 2'b10);
        setVec(2, 1'b0, 24'h000020, 8'd2, 3'd2, 2'b00);
        for (int b = 0; b < 3; b++) setBeat(2, b, 1'b1, 10'h008, 32'h5A00_0008, 2'b00);
        setVec(3, 1'b1, 24'h000100, 8'd1, 3'd1, 2'b01);
        for (int b = 0; b < 2; b++) setBeat(3, b, 1'b0, 10'h000, 32'h0000_0000, 2'b10);
        setVec(4, 1'b0, 24'h000100, 8'd1, 3'd2, 2'b10);
        for (int b = 0; b < 2; b++) setBeat(4, b, 1'b0, 10'h000, 32'h0000_0000, 2'b10);
        setVec(5, 1'b1, 24'h0003FC, 8'd0, 3'd2, 2'b01);
        setBeat(5, 0, 1'b1, 10'h0FF, 32'h5A00_00FF, 2'b00);

        reset       = 1'b1;
        axi.arvalid = 1'b0;
        axi.arid    = '0;
        axi.araddr  = '0;
        axi.arlen   = '0;
        axi.arsize  = '0;
        axi.arburst = '0;
        axi.rready  = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        reset = 1'b0;

        @(negedge clk_i);
        checkOutput("reset arready", 32'(axi.arready), 32'd1);
        checkOutput("reset rvalid", 32'(axi.rvalid), 32'd0);
        checkOutput("reset rlast", 32'(axi.rlast), 32'd0);
        checkOutput("reset rresp", 32'(axi.rresp), 32'd0);
        checkOutput("reset rid", 32'(axi.rid), 32'd0);
        checkOutput("reset rdata", axi.rdata, 32'd0);
        checkOutput("reset mem_en", 32'(mem_en), 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);

        for (int v = 0; v < 6; v++) applyStimulus(v);

        // Backpressure: beat 2 held for three stalled edges with no RAM access
        issueAr("stall", 1'b0, 24'h000040, 8'd3, 3'd2, 2'b01);
        checkFetch("stall.b0", 1'b1, 10'h010);
        checkData("stall.b0", 1'b0, 32'h5A00_0010, 2'b00, 1'b0);
        checkFetch("stall.b1", 1'b1, 10'h011);
        axi.rready = 1'b0;
        for (int s = 0; s < 4; s++)
            checkData($sformatf("stall.b1.s%0d", s), 1'b0, 32'h5A00_0011, 2'b00, 1'b0);
        axi.rready = 1'b1;
        checkFetch("stall.b2", 1'b1, 10'h012);
        checkData("stall.b2", 1'b0, 32'h5A00_0012, 2'b00, 1'b0);
        checkFetch("stall.b3", 1'b1, 10'h013);
        checkData("stall.b3", 1'b0, 32'h5A00_0013, 2'b00, 1'b1);
        checkIdle("stall");

        // Reset while beat 2 is on the bus abandons the burst
        issueAr("rst", 1'b0, 24'h000040, 8'd3, 3'd2, 2'b01);
        checkFetch("rst.b0", 1'b1, 10'h010);
        checkData("rst.b0", 1'b0, 32'h5A00_0010, 2'b00, 1'b0);
        checkFetch("rst.b1", 1'b1, 10'h011);
        checkData("rst.b1", 1'b0, 32'h5A00_0011, 2'b00, 1'b0);
        reset = 1'b1;
        @(posedge clk_i);
        #1;
        reset = 1'b0;
        checkIdle("rst");
        issueAr("rst.new", 1'b1, 24'h000044, 8'd0, 3'd2, 2'b01);
        checkFetch("rst.new", 1'b1, 10'h011);
        checkData("rst.new", 1'b1, 32'h5A00_0011, 2'b00, 1'b1);
        checkIdle("rst.new");

        // Maximum burst length: 256 beats, rlast only on the final one
        issueAr("max", 1'b0, 24'h000000, 8'hFF, 3'd2, 2'b01);
        for (int b = 0; b < 256; b++) begin
            checkFetch($sformatf("max.b%0d", b), 1'b1, 10'(b));
            checkData($sformatf("max.b%0d", b), 1'b0, 32'h5A00_0000 | 32'(b), 2'b00, b == 255);
        end
        checkIdle("max");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
